// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset sequencer.
//   - state_t       : FSM state encoding, also exported on state_o for debug
//   - rst_outs_t    : the four registered control outputs as one bundle
//   - outs_for()    : output values that belong to a given state
package rst_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        PHY_HOLD  = 3'd1,
        WAIT_CAL  = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    typedef struct packed {
        logic phy_rst;
        logic core_rst;
        logic seq_done;
        logic seq_fail;
    } rst_outs_t;

    // Outputs are a pure function of the state being entered, so both
    // reset domains change on the very edge the state changes.
    function automatic rst_outs_t outs_for(state_t s);
        rst_outs_t o;
        o = '{phy_rst: 1'b1, core_rst: 1'b1, seq_done: 1'b0, seq_fail: 1'b0};
        case (s)
            WAIT_CAL: o.phy_rst  = 1'b0;
            RUN: begin
                o.phy_rst  = 1'b0;
                o.core_rst = 1'b0;
                o.seq_done = 1'b1;
            end
            FAIL:     o.seq_fail = 1'b1;
            default:  ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_signal.sv
// sync_signal: generic N-flop level synchronizer for a single asynchronous bit.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears every stage to 0
//   d   - asynchronous input level
//   q   - synchronized level, N clk edges behind d
module sync_signal #(
    parameter int N = 2   // number of flops, at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: sequences the PHY reset domain and then the core reset domain
// after PLL lock has been stable, waits for PHY calibration with timeout and
// bounded retry, and reports done / sticky failure.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset from the reset synchronizer
//   pll_locked - PLL lock, asynchronous to clk (synchronized internally)
//   phy_ready  - PHY calibration complete, synchronous to clk
//   phy_rst    - active-high reset to the DDR/Ethernet PHY
//   core_rst   - active-high reset to the core logic
//   seq_done   - high while in RUN
//   seq_fail   - high in FAIL (left only through rst)
//   retry_cnt  - calibration timeouts taken so far
//   state_o    - current state encoding, for debug
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int LOCK_CYCLES     = 1024,
    parameter int PHY_HOLD_CYCLES = 256,
    parameter int CAL_TIMEOUT     = 65536,
    parameter int MAX_RETRY       = 3,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       phy_ready,
    output logic       phy_rst,
    output logic       core_rst,
    output logic       seq_done,
    output logic       seq_fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    // Elaboration-time guard: the shared counter must reach every terminal count.
    if (CNT_W < 1 || CNT_W > 62 ||
        (64'd1 << CNT_W) < 64'(LOCK_CYCLES) ||
        (64'd1 << CNT_W) < 64'(PHY_HOLD_CYCLES) ||
        (64'd1 << CNT_W) < 64'(CAL_TIMEOUT) ||
        LOCK_CYCLES < 1 || PHY_HOLD_CYCLES < 1 || CAL_TIMEOUT < 1 ||
        MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_param_check
        $error("rst_sequencer: illegal parameter combination (CNT_W too narrow or value out of range)");
    end

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PHY_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    logic             locked_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       retry_q, retry_n;
    rst_outs_t        outs_q;

    sync_signal #(.N(2)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // NOTE: every variable written here gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry_q;

        // Lock loss outranks every other transition once sequencing has begun.
        if (!locked_s && (state == PHY_HOLD || state == WAIT_CAL || state == RUN)) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!locked_s) begin
                        cnt_n = '0;
                    end else if (cnt == LOCK_LAST) begin
                        state_n = PHY_HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                PHY_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_n = WAIT_CAL;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                WAIT_CAL: begin
                    // Readiness is tested first so success wins on the timeout cycle.
                    if (phy_ready) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else if (cnt == CAL_LAST) begin
                        cnt_n = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_n = retry_q + 2'd1;
                            state_n = PHY_HOLD;
                        end else begin
                            state_n = FAIL;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!phy_ready) begin
                        state_n = PHY_HOLD;
                        cnt_n   = '0;
                    end
                end
                FAIL: ;
                default: begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            retry_q <= '0;
            outs_q  <= outs_for(WAIT_LOCK);
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            retry_q <= retry_n;
            outs_q  <= outs_for(state_n);
        end
    end

    assign phy_rst   = outs_q.phy_rst;
    assign core_rst  = outs_q.core_rst;
    assign seq_done  = outs_q.seq_done;
    assign seq_fail  = outs_q.seq_fail;
    assign retry_cnt = retry_q;
    assign state_o   = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench for rst_sequencer. The driver applies
// directed and random stimulus once per cycle, advances a behavioural model
// (countdowns and phase names) and queues the outputs expected after the
// coming edge; an independent monitor pops one entry after every edge and
// compares it against the DUT outputs.
module tb_rst_sequencer;

    localparam int LOCK_CYCLES     = 4;
    localparam int PHY_HOLD_CYCLES = 8;
    localparam int CAL_TIMEOUT     = 16;
    localparam int MAX_RETRY       = 2;
    localparam int CNT_W           = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       phy_ready = 1'b0;
    logic       phy_rst, core_rst, seq_done, seq_fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    rst_sequencer #(
        .LOCK_CYCLES     (LOCK_CYCLES),
        .PHY_HOLD_CYCLES (PHY_HOLD_CYCLES),
        .CAL_TIMEOUT     (CAL_TIMEOUT),
        .MAX_RETRY       (MAX_RETRY),
        .CNT_W           (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .phy_ready  (phy_ready),
        .phy_rst    (phy_rst),
        .core_rst   (core_rst),
        .seq_done   (seq_done),
        .seq_fail   (seq_fail),
        .retry_cnt  (retry_cnt),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef enum int {P_LOCK = 0, P_HOLD = 1, P_CAL = 2, P_RUN = 3, P_FAIL = 4} phase_t;

    phase_t m_phase = P_LOCK;
    int     m_stable = 0;     // consecutive qualified-lock edges seen
    int     m_left = 0;       // PHY hold edges still to go
    int     m_waited = 0;     // calibration edges spent without ready
    int     m_retries = 0;
    bit     m_s1 = 1'b0, m_s2 = 1'b0;   // two-stage lock delay line

    task automatic model_edge(input logic r, input logic lk, input logic rdy);
        bit ls;
        ls = m_s2;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0;
            m_phase = P_LOCK; m_stable = 0; m_retries = 0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = lk;
        if (!ls && m_phase inside {P_HOLD, P_CAL, P_RUN}) begin
            m_phase = P_LOCK;
            m_stable = 0;
            return;
        end
        case (m_phase)
            P_LOCK: begin
                if (!ls) m_stable = 0;
                else begin
                    m_stable++;
                    if (m_stable == LOCK_CYCLES) begin
                        m_phase = P_HOLD;
                        m_left = PHY_HOLD_CYCLES;
                    end
                end
            end
            P_HOLD: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_CAL;
                    m_waited = 0;
                end
            end
            P_CAL: begin
                if (rdy) m_phase = P_RUN;
                else begin
                    m_waited++;
                    if (m_waited == CAL_TIMEOUT) begin
                        if (m_retries < MAX_RETRY) begin
                            m_retries++;
                            m_phase = P_HOLD;
                            m_left = PHY_HOLD_CYCLES;
                        end else begin
                            m_phase = P_FAIL;
                        end
                    end
                end
            end
            P_RUN: begin
                if (!rdy) begin
                    m_phase = P_HOLD;
                    m_left = PHY_HOLD_CYCLES;
                end
            end
            default: ;
        endcase
    endtask

    // {phy_rst, core_rst, seq_done, seq_fail, retry_cnt[1:0], state_o[2:0]}
    function automatic logic [8:0] expect_vec();
        logic pr, cr, sd, sf;
        pr = (m_phase == P_LOCK) || (m_phase == P_HOLD) || (m_phase == P_FAIL);
        cr = (m_phase != P_RUN);
        sd = (m_phase == P_RUN);
        sf = (m_phase == P_FAIL);
        return {pr, cr, sd, sf, 2'(m_retries), 3'(int'(m_phase))};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [8:0] v;
        int         edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (phy_rst,core_rst,seq_done,seq_fail,retry_cnt,state_o)",
                     name, act, req);
        end
    endtask

    // Monitor: one expected entry per edge, sampled 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("edge%0d", e.edge_no),
                      {phy_rst, core_rst, seq_done, seq_fail, retry_cnt, state_o}, e.v);
            end
        end
    end

    // Apply inputs for the coming edge, predict its result, wait for the next negedge.
    task automatic drive(input logic r, input logic lk, input logic rdy);
        exp_t e;
        rst = r;
        pll_locked = lk;
        phy_ready = rdy;
        model_edge(r, lk, rdy);
        e.v = expect_vec();
        e.edge_no = edge_cnt;
        edge_cnt++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int n;

        // 1. Clean bring-up: ready first sampled on edge 21.
        do_reset(3);
        for (int e = 0; e < 40; e++) drive(1'b0, 1'b1, e >= 21);

        // 2. One-cycle lock glitch while qualifying lock.
        do_reset(2);
        k = $urandom_range(1, 3);
        for (int e = 0; e < 40; e++) drive(1'b0, e != k, e >= 26);

        // 3. First calibration window times out, second succeeds.
        do_reset(2);
        k = $urandom_range(0, 10);
        for (int i = 0; i < 150 && m_phase != P_RUN; i++)
            drive(1'b0, 1'b1, m_retries >= 1 && m_phase == P_CAL && m_waited >= k);
        repeat (5) drive(1'b0, 1'b1, 1'b1);

        // 4. Retries exhausted, FAIL is absorbing, rst clears it.
        do_reset(2);
        repeat (100) drive(1'b0, 1'b1, 1'b0);
        repeat (20) drive(1'b0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0);

        // 5. Lock loss in RUN, re-lock, then a recalibration from RUN.
        do_reset(2);
        for (int i = 0; i < 60 && m_phase != P_RUN; i++) drive(1'b0, 1'b1, m_phase == P_CAL);
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        n = $urandom_range(1, 5);
        repeat (n) drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 60 && m_phase != P_RUN; i++)
            drive(1'b0, 1'b1, m_phase == P_CAL && m_waited >= 3);
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, m_phase == P_CAL);

        // 6a. rst in the middle of a calibration window.
        do_reset(2);
        for (int i = 0; i < 40 && !(m_phase == P_CAL && m_waited == 5); i++)
            drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 1'b0);

        // 6b. rst exactly on a timeout edge: the retry increment must not land.
        do_reset(2);
        for (int i = 0; i < 100 && !(m_phase == P_CAL && m_retries == 1 && m_waited == CAL_TIMEOUT - 1); i++)
            drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0);

        // 7. Random soak.
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            logic r, lk, rdy;
            r  = ($urandom_range(0, 199) == 0);
            lk = ($urandom_range(0, 59) != 0);
            if (m_phase == P_CAL)      rdy = ($urandom_range(0, 19) == 0);
            else if (m_phase == P_RUN) rdy = ($urandom_range(0, 49) != 0);
            else                       rdy = ($urandom_range(0, 1) != 0);
            drive(r, lk, rdy);
        end

        // Drain: the monitor pops the last entry one edge after it was queued.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
